// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-RAM arbiter.
// Default widths describe a 4096 x 32 single-port RAM.
package imem_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Loader, fetch and RAM-port signals of the instruction-RAM arbiter.
// The slave view belongs to the arbiter and the master view to its surroundings.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);
    logic              ld_valid_in;
    logic              ld_ready_out;
    logic [ADDR_W-1:0] ld_addr_in;
    logic [DATA_W-1:0] ld_data_in;
    logic              ld_last_in;

    logic              if_req_in;
    logic [ADDR_W-1:0] if_addr_in;
    logic              if_gnt_out;
    logic              if_valid_out;
    logic [DATA_W-1:0] if_rdata_out;

    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic [DATA_W-1:0] mem_rdata_in;

    logic              core_rst_out;
    logic [ADDR_W:0]   boot_cnt_out;

    modport slave (
        input  ld_valid_in, ld_addr_in, ld_data_in, ld_last_in,
        input  if_req_in, if_addr_in, mem_rdata_in,
        output ld_ready_out, if_gnt_out, if_valid_out, if_rdata_out,
        output mem_we_out, mem_addr_out, mem_wdata_out,
        output core_rst_out, boot_cnt_out
    );

    modport master (
        output ld_valid_in, ld_addr_in, ld_data_in, ld_last_in,
        output if_req_in, if_addr_in, mem_rdata_in,
        input  ld_ready_out, if_gnt_out, if_valid_out, if_rdata_out,
        input  mem_we_out, mem_addr_out, mem_wdata_out,
        input  core_rst_out, boot_cnt_out
    );

endinterface

// File: rtl/imem_streak_ctr.sv
// Counts consecutive loader grants taken while a fetch waits; saturates at the limit.
// force_fetch_o is registered state, so the fetch wins the cycle after the limit is reached.
module imem_streak_ctr #(
    parameter int MAX_WR_STREAK = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_fetch_o
);
    localparam int               CNT_W = $clog2(MAX_WR_STREAK + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WR_STREAK);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch_o = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Owns the instruction RAM: boot-time sequential loader fill, then per-cycle loader/fetch arbitration.
// Grants are combinational, fetch data arrives one cycle after its grant; the loader stalls on ld_ready_out=0.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W        = IMEM_ADDR_W,
    parameter int DATA_W        = IMEM_DATA_W,
    parameter int MAX_WR_STREAK = 4
) (
    input logic           clk_in,
    input logic           rst_in,
    imem_arbiter_if.slave bus
);
    localparam logic [0:0] ST_BOOT = BOOT;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] boot_ptr_q, boot_ptr_d;
    logic [ADDR_W:0]   boot_cnt_q, boot_cnt_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;

    logic              ld_ready;
    logic              ld_acc;
    logic              fetch_gnt;
    logic              force_fetch;
    logic              streak_inc;
    logic [ADDR_W-1:0] mem_addr;

    // Nothing is granted in the reset cycle so RAM contents survive a reset.
    always_comb begin
        ld_ready  = 1'b0;
        fetch_gnt = 1'b0;
        if (!rst_in) begin
            if (state_q == ST_BOOT) begin
                ld_ready = 1'b1;
            end else begin
                ld_ready  = !(force_fetch && bus.if_req_in);
                fetch_gnt = bus.if_req_in && !(bus.ld_valid_in && ld_ready);
            end
        end
    end

    assign ld_acc = bus.ld_valid_in && ld_ready;

    always_comb begin
        mem_addr = bus.if_addr_in;
        if (ld_acc) begin
            mem_addr = (state_q == ST_BOOT) ? boot_ptr_q : bus.ld_addr_in;
        end
    end

    // Leaving boot on the last RAM word means the wrapped pointer is never used for a write.
    always_comb begin
        state_d    = state_q;
        boot_ptr_d = boot_ptr_q;
        boot_cnt_d = boot_cnt_q;
        if ((state_q == ST_BOOT) && ld_acc) begin
            boot_ptr_d = boot_ptr_q + ADDR_W'(1);
            boot_cnt_d = boot_cnt_q + (ADDR_W + 1)'(1);
            if (bus.ld_last_in || (&boot_ptr_q)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        if_valid_d = fetch_gnt;
        if_rdata_d = fetch_gnt ? bus.mem_rdata_in : if_rdata_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_BOOT;
            boot_ptr_q <= '0;
            boot_cnt_q <= '0;
            if_valid_q <= 1'b0;
            if_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_ptr_q <= boot_ptr_d;
            boot_cnt_q <= boot_cnt_d;
            if_valid_q <= if_valid_d;
            if_rdata_q <= if_rdata_d;
        end
    end

    // Only loader grants that keep a fetch waiting extend the streak; any other cycle restarts it.
    assign streak_inc = (state_q == ST_RUN) && ld_acc && bus.if_req_in;

    imem_streak_ctr #(
        .MAX_WR_STREAK(MAX_WR_STREAK)
    ) u_streak (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .inc_i        (streak_inc),
        .clr_i        (!streak_inc),
        .force_fetch_o(force_fetch)
    );

    assign bus.ld_ready_out  = ld_ready;
    assign bus.if_gnt_out    = fetch_gnt;
    assign bus.if_valid_out  = if_valid_q;
    assign bus.if_rdata_out  = if_rdata_q;
    assign bus.mem_we_out    = ld_acc;
    assign bus.mem_addr_out  = mem_addr;
    assign bus.mem_wdata_out = bus.ld_data_in;
    assign bus.core_rst_out  = rst_in || (state_q == ST_BOOT);
    assign bus.boot_cnt_out  = boot_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a cycle table for boot/fetch/streak/patch, then reset and full-RAM boot sequences.
module tb_imem_arbiter;

    logic clk;
    logic rst;

    logic [31:0] ram [4096];

    int n_tests;
    int n_fail;

    imem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    imem_arbiter #(
        .ADDR_W(12),
        .DATA_W(32),
        .MAX_WR_STREAK(4)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata_in = ram[bus.mem_addr_out];

    always @(posedge clk) begin
        if (bus.mem_we_out) ram[bus.mem_addr_out] <= bus.mem_wdata_out;
    end

    typedef struct {
        logic        ld_v;
        logic [11:0] ld_a;
        logic [31:0] ld_d;
        logic        ld_l;
        logic        if_r;
        logic [11:0] if_a;
        logic        e_rdy;
        logic        e_gnt;
        logic        e_we;
        logic [11:0] e_addr;
        logic        e_crst;
        logic        e_vld;
        logic [31:0] e_rdata;
        logic [12:0] e_cnt;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic ld_v, logic [11:0] ld_a, logic [31:0] ld_d, logic ld_l,
                                logic if_r, logic [11:0] if_a,
                                logic e_rdy, logic e_gnt, logic e_we, logic [11:0] e_addr,
                                logic e_crst, logic e_vld, logic [31:0] e_rdata, logic [12:0] e_cnt);
        vec_t v;
        v.ld_v = ld_v;   v.ld_a = ld_a;     v.ld_d = ld_d;     v.ld_l = ld_l;
        v.if_r = if_r;   v.if_a = if_a;
        v.e_rdy = e_rdy; v.e_gnt = e_gnt;   v.e_we = e_we;     v.e_addr = e_addr;
        v.e_crst = e_crst; v.e_vld = e_vld; v.e_rdata = e_rdata; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld_v, input logic [11:0] ld_a, input logic [31:0] ld_d,
                         input logic ld_l, input logic if_r, input logic [11:0] if_a);
        bus.ld_valid_in = ld_v;
        bus.ld_addr_in  = ld_a;
        bus.ld_data_in  = ld_d;
        bus.ld_last_in  = ld_l;
        bus.if_req_in   = if_r;
        bus.if_addr_in  = if_a;
    endtask

    function automatic logic [127:0] obs();
        return {34'd0, bus.ld_ready_out, bus.if_gnt_out, bus.mem_we_out, bus.mem_addr_out,
                bus.core_rst_out, bus.if_valid_out, bus.if_rdata_out, bus.boot_cnt_out,
                bus.mem_wdata_out};
    endfunction

    initial begin
        int bad;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;

        vecs[0]  = mk(1, 12'h000, 32'h00000013, 0, 1, 12'h005, 1, 0, 1, 12'h000, 1, 0, 32'h0, 13'd0);
        vecs[1]  = mk(1, 12'h000, 32'h00100093, 0, 1, 12'h005, 1, 0, 1, 12'h001, 1, 0, 32'h0, 13'd1);
        vecs[2]  = mk(1, 12'h000, 32'h00208113, 1, 0, 12'h000, 1, 0, 1, 12'h002, 1, 0, 32'h0, 13'd2);
        vecs[3]  = mk(0, 12'h000, 32'h0, 0, 1, 12'h001, 1, 1, 0, 12'h001, 0, 0, 32'h0, 13'd3);
        vecs[4]  = mk(0, 12'h000, 32'h0, 0, 1, 12'h001, 1, 1, 0, 12'h001, 0, 1, 32'h00100093, 13'd3);
        vecs[5]  = mk(0, 12'h000, 32'h0, 0, 1, 12'h000, 1, 1, 0, 12'h000, 0, 1, 32'h00100093, 13'd3);
        vecs[6]  = mk(0, 12'h000, 32'h0, 0, 0, 12'h002, 1, 0, 0, 12'h002, 0, 1, 32'h00000013, 13'd3);
        vecs[7]  = mk(0, 12'h000, 32'h0, 0, 0, 12'h002, 1, 0, 0, 12'h002, 0, 0, 32'h00000013, 13'd3);
        vecs[8]  = mk(1, 12'h010, 32'hA0000000, 0, 1, 12'h000, 1, 0, 1, 12'h010, 0, 0, 32'h00000013, 13'd3);
        vecs[9]  = mk(1, 12'h011, 32'hA0000001, 0, 1, 12'h000, 1, 0, 1, 12'h011, 0, 0, 32'h00000013, 13'd3);
        vecs[10] = mk(1, 12'h012, 32'hA0000002, 0, 1, 12'h000, 1, 0, 1, 12'h012, 0, 0, 32'h00000013, 13'd3);
        vecs[11] = mk(1, 12'h013, 32'hA0000003, 0, 1, 12'h000, 1, 0, 1, 12'h013, 0, 0, 32'h00000013, 13'd3);
        vecs[12] = mk(1, 12'h014, 32'hA0000004, 0, 1, 12'h000, 0, 1, 0, 12'h000, 0, 0, 32'h00000013, 13'd3);
        vecs[13] = mk(1, 12'h014, 32'hA0000004, 0, 1, 12'h000, 1, 0, 1, 12'h014, 0, 1, 32'h00000013, 13'd3);
        vecs[14] = mk(0, 12'h000, 32'h0, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 32'h00000013, 13'd3);
        vecs[15] = mk(1, 12'h002, 32'hDEADBEEF, 1, 0, 12'h000, 1, 0, 1, 12'h002, 0, 0, 32'h00000013, 13'd3);
        vecs[16] = mk(0, 12'h000, 32'h0, 0, 1, 12'h002, 1, 1, 0, 12'h002, 0, 0, 32'h00000013, 13'd3);
        vecs[17] = mk(0, 12'h000, 32'h0, 0, 1, 12'h012, 1, 1, 0, 12'h012, 0, 1, 32'hDEADBEEF, 13'd3);
        vecs[18] = mk(0, 12'h000, 32'h0, 0, 1, 12'h014, 1, 1, 0, 12'h014, 0, 1, 32'hA0000002, 13'd3);
        vecs[19] = mk(0, 12'h000, 32'h0, 0, 0, 12'h003, 1, 0, 0, 12'h003, 0, 1, 32'hA0000004, 13'd3);
        vecs[20] = mk(0, 12'h000, 32'h0, 0, 0, 12'h003, 1, 0, 0, 12'h003, 0, 0, 32'hA0000004, 13'd3);

        // Power-on reset, checking the combinational outputs inside the reset cycle.
        rst = 1'b1;
        drive(1, 12'h000, 32'h11111111, 0, 1, 12'h001);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_cycle", {125'd0, bus.ld_ready_out, bus.if_gnt_out, bus.mem_we_out},
            {125'd0, 1'b0, 1'b0, 1'b0});
        chk("reset_core_rst", {127'd0, bus.core_rst_out}, {127'd0, 1'b1});

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ld_v, vecs[i].ld_a, vecs[i].ld_d, vecs[i].ld_l, vecs[i].if_r, vecs[i].if_a);
            #1;
            chk($sformatf("vec%0d", i), obs(),
                {34'd0, vecs[i].e_rdy, vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_addr,
                 vecs[i].e_crst, vecs[i].e_vld, vecs[i].e_rdata, vecs[i].e_cnt, vecs[i].ld_d});
        end

        // Reset mid-RUN right after a fetch grant.
        @(negedge clk);
        drive(0, 12'h000, 32'h0, 0, 1, 12'h001);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 12'h001, 32'h55555555, 0, 1, 12'h001);
        #1;
        chk("midrun_reset_cycle", {124'd0, bus.ld_ready_out, bus.if_gnt_out, bus.mem_we_out, bus.core_rst_out},
            {124'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        drive(0, 12'h000, 32'h0, 0, 0, 12'h000);
        #1;
        chk("after_reset_state", {80'd0, bus.ld_ready_out, bus.core_rst_out, bus.if_valid_out,
                                   bus.if_rdata_out, bus.boot_cnt_out},
            {80'd0, 1'b1, 1'b1, 1'b0, 32'h0, 13'd0});
        chk("ram1_kept", {96'd0, ram[1]}, {96'd0, 32'h00100093});
        chk("ram2_patched", {96'd0, ram[2]}, {96'd0, 32'hDEADBEEF});

        // Full boot without ld_last_in: 4096 sequential writes, fetch blocked throughout.
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i != 0) @(negedge clk);
            drive(1, 12'h7FF, 32'hC0000000 | 32'(i), 0, 1, 12'h123);
            #1;
            if (!(bus.mem_we_out && bus.ld_ready_out && !bus.if_gnt_out && bus.core_rst_out &&
                  bus.mem_addr_out == 12'(i) && bus.boot_cnt_out == 13'(i))) bad++;
        end
        chk("full_boot_writes", {96'd0, 32'(bad)}, {96'd0, 32'd0});

        @(negedge clk);
        drive(1, 12'h0AB, 32'h12345678, 0, 0, 12'h000);
        #1;
        chk("full_boot_run", {96'd0, bus.core_rst_out, bus.boot_cnt_out, bus.mem_we_out, bus.mem_addr_out},
            {96'd0, 1'b0, 13'd4096, 1'b1, 12'h0AB});

        @(negedge clk);
        drive(0, 12'h000, 32'h0, 0, 1, 12'hFFF);
        #1;
        chk("fetch_last_gnt", {127'd0, bus.if_gnt_out}, {127'd0, 1'b1});
        @(negedge clk);
        drive(0, 12'h000, 32'h0, 0, 0, 12'h000);
        #1;
        chk("fetch_last_data", {95'd0, bus.if_valid_out, bus.if_rdata_out}, {95'd0, 1'b1, 32'hC0000FFF});
        chk("no_wrap_write", {96'd0, ram[0]}, {96'd0, 32'hC0000000});
        chk("run_patch_after_full", {96'd0, ram[12'h0AB]}, {96'd0, 32'h12345678});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
